load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access initiator between the execute stage and the word-addressable data memory. It accepts one load or store per handshake and issues word-wide read/write strobes to the memory. It extracts and sign/zero-extends byte, half, word and doubleword loads. It implements byte, half and word stores as read-modify-write of the containing 64-bit word. Misaligned accesses are rejected with an error response and cause no memory traffic.

## Interface
- ADDR_WIDTH, 64, byte-address width of requests and of the memory address port
- DATA_WIDTH, 64, memory word width; fixed at 64 (8 bytes/word, offset = addr[2:0])

- clk_in  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, request accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 double
- req_unsigned  input  1  zero-extend loads (ignored for double and for stores)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-justified
- resp_valid  output  1  response present
- resp_ready  input  1  response consumed when resp_valid && resp_ready
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned access
- mem_addr  output  ADDR_WIDTH  word-aligned address (low 3 bits 0)
- mem_wdata  output  DATA_WIDTH  full word to write
- mem_write  output  1  memory write enable
- mem_read  output  1  memory read enable
- mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr/mem_read

## Operation
- States: IDLE, RD, WR, DONE. req_ready = (state==IDLE).
- On accept, the unit registers write, size, unsigned, addr and wdata. A request is misaligned when addr mod 2^size != 0.
- IDLE transitions on accept:
  - misaligned -> DONE with err=1
  - load -> RD
  - store, size 3 -> WR
  - store, size <3 -> RD
- RD: mem_read=1 and mem_addr = {addr[ADDR_WIDTH-1:3],3'b0}. At the posedge the unit captures mem_rdata into word_q. A load then goes to DONE; a store goes to WR.
- WR: mem_write=1. For size 3, mem_wdata = wdata. For size <3, mem_wdata = word_q with bytes [off, off+2^size) replaced by the low 2^size bytes of wdata (little-endian); all other bytes are unchanged. Next state is DONE.
- DONE: resp_valid=1, outputs held stable until resp_ready. The unit then returns to IDLE; no request is accepted in the DONE->IDLE edge cycle.
- Load data: lane = word_q >> (8*off), truncated to 2^size bytes. It is sign-extended unless req_unsigned, and never extended for double.
- mem_read and mem_write are never high together, never high outside RD/WR, and both are gated low whenever reset=1.
- Reset values: state IDLE, req_ready=1 (after reset is released), resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0, word_q=0.
- Reset mid-operation (any state) aborts the operation. No write is issued in the reset cycle, and the response is discarded.

## Timing
- Accept at edge k; the following latencies count to the first resp_valid cycle:
  - misaligned: cycle k+1 (1 cycle)
  - double store: WR in cycle k+1, DONE at k+2
  - load: RD in k+1, DONE at k+2
  - sub-word store: RD k+1, WR k+2, DONE k+3
- Exactly one mem_read cycle per load or sub-word store, and exactly one mem_write cycle per store.
- Throughput is at most one request per (latency + 1) cycles with resp_ready held high.
- Backpressure: while resp_ready=0, resp_* stay constant, req_ready=0 and there is no memory traffic.

## Test plan
- Preload word 0x40 = 0x8877665544332211.
  - lb 0x47 -> resp_rdata 0xFFFFFFFFFFFFFF88, resp_valid at k+2, one mem_read cycle.
  - lbu 0x47 -> 0x0000000000000088.
  - lw 0x44 -> 0xFFFFFFFF88776655.
- sh 0xBEEF to 0x42 -> mem_read at k+1, mem_write at k+2 with mem_wdata 0x88776655BEEF2211. A later ld 0x40 returns 0x88776655BEEF2211.
- sd 0x0123456789ABCDEF to 0x48 -> single mem_write at k+1 with mem_addr 0x48, no mem_read, resp_rdata 0, resp_err 0 at k+2.
- Misaligned requests:
  - lw 0x46 -> resp_err=1, resp_rdata=0 at k+1, mem_read/mem_write never asserted.
  - sh 0x43 -> same response, no mem_write.
- Backpressure: hold resp_ready=0 for 3 cycles after a load. resp_valid/resp_rdata must stay stable and req_ready=0 with a new req_valid pending. That request is accepted only in the cycle after resp_ready pulses.
- Assert reset during WR of a sub-word store -> mem_write=0 in that cycle. Next cycle: IDLE, req_ready=1, resp_valid=0, all mem outputs 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 64-bit word-addressable data memory.
// Loads read one word and extract a sign/zero-extended lane; sub-word stores do
// read-modify-write of the containing word; misaligned requests error out with
// no memory traffic.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [2:0]            off_q, off_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    // An access is aligned when the offset is a multiple of its byte count.
    function automatic logic is_misaligned(logic [2:0] off, logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract(logic [DATA_WIDTH-1:0] word,
                                                      logic [2:0] off, logic [1:0] size,
                                                      logic uns);
        logic [DATA_WIDTH-1:0] lane;
        lane = word >> {off, 3'b000};
        case (size)
            2'd0: return uns ? {{(DATA_WIDTH-8){1'b0}}, lane[7:0]}
                             : {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            2'd1: return uns ? {{(DATA_WIDTH-16){1'b0}}, lane[15:0]}
                             : {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            2'd2: return uns ? {{(DATA_WIDTH-32){1'b0}}, lane[31:0]}
                             : {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
            default: return lane;
        endcase
    endfunction

    // Little-endian byte-lane replace of the low 2^size bytes of wdata at off.
    function automatic logic [DATA_WIDTH-1:0] merge(logic [DATA_WIDTH-1:0] word,
                                                    logic [DATA_WIDTH-1:0] wdata,
                                                    logic [2:0] off, logic [1:0] size);
        logic [DATA_WIDTH-1:0] res;
        int                    nbytes;
        int                    j;
        res    = word;
        nbytes = 1 << size;
        for (int i = 0; i < 8; i++) begin
            j = i - int'(off);
            if (j >= 0 && j < nbytes) begin
                res[8*i +: 8] = wdata[8*j +: 8];
            end
        end
        return res;
    endfunction

    // Next-state and request capture.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        off_d      = off_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    off_d      = req_addr[2:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = {req_addr[ADDR_WIDTH-1:3], 3'b000};
                    err_d      = is_misaligned(req_addr[2:0], req_size);
                    if (err_d) begin
                        state_d = StDone;
                    end else if (req_write && req_size == 2'd3) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                word_d  = mem_rdata;
                state_d = write_q ? StWr : StDone;
            end
            StWr: begin
                state_d = StDone;
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts whatever operation is in flight.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            off_q      <= 3'd0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            off_q      <= off_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
        end
    end

    // Outputs decode from registered state; strobes are forced low under reset.
    always_comb begin
        req_ready  = (state_q == StIdle) && !reset;
        resp_valid = (state_q == StDone) && !reset;
        resp_err   = (state_q == StDone) && err_q;
        resp_rdata = '0;
        if (state_q == StDone && !write_q && !err_q) begin
            resp_rdata = extract(word_q, off_q, size_q, unsigned_q);
        end
        mem_addr  = mem_addr_q;
        mem_read  = (state_q == StRd) && !reset;
        mem_write = (state_q == StWr) && !reset;
        mem_wdata = '0;
        if (state_q == StWr) begin
            mem_wdata = (size_q == 2'd3) ? wdata_q : merge(word_q, wdata_q, off_q, size_q);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-word memory fixture, a transaction-level
// reference memory and load/store model, directed cases then random traffic.
module tb_load_store_unit;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [63:0] fmem [32];
    logic [63:0] ref_mem [32];
    int          n_total = 0;
    int          n_pass = 0;

    load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk_in(clk_in), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    assign mem_rdata = fmem[mem_addr[7:3]];

    always @(posedge clk_in) begin
        if (mem_write) fmem[mem_addr[7:3]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got timeout, expected DUT event", name);
    endtask

    function automatic logic [63:0] model_load(logic [63:0] word, logic [2:0] off,
                                               logic [1:0] sz, logic uns);
        int          nb;
        logic [63:0] v;
        logic [63:0] m;
        nb = 1 << sz;
        v  = word >> (8 * int'(off));
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (!uns && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [63:0] model_store(logic [63:0] word, logic [63:0] wd,
                                                logic [2:0] off, logic [1:0] sz);
        int          nb;
        logic [63:0] m;
        nb = 1 << sz;
        m  = (nb == 8) ? ~64'd0 : (64'd1 << (8 * nb)) - 64'd1;
        return (word & ~(m << (8 * int'(off)))) | ((wd & m) << (8 * int'(off)));
    endfunction

    // Strobes are mutually exclusive every cycle and low under reset.
    always @(negedge clk_in) begin
        check("strobe_exclusive", 64'(mem_read && mem_write), 64'd0);
        if (reset) check("reset_gates_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] wd, input int stall,
                          input logic pin, input logic [63:0] pin_val);
        logic        mis;
        int          idx, exp_lat, lat, nrd, nwr, wait_c;
        logic [2:0]  off;
        logic [63:0] exp_rd, exp_word;
        off      = a[2:0];
        idx      = int'(a[7:3]);
        mis      = (a % (64'd1 << sz)) != 64'd0;
        exp_word = ref_mem[idx];
        exp_rd   = 64'd0;
        if (!mis && !w) exp_rd = model_load(ref_mem[idx], off, sz, u);
        if (!mis && w) exp_word = model_store(ref_mem[idx], wd, off, sz);
        exp_lat = mis ? 1 : (w && sz != 2'd3) ? 3 : 2;
        if (pin) check("model_pin", w ? exp_word : exp_rd, pin_val);

        wait_c = 0;
        while (!req_ready && wait_c < 20) begin
            @(negedge clk_in);
            wait_c++;
        end
        if (!req_ready) begin
            fail("req_ready_wait");
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; resp_ready = 1'b0;
        @(posedge clk_in);
        lat = 0; nrd = 0; nwr = 0;
        do begin
            @(negedge clk_in);
            req_valid = 1'b0;
            lat++;
            if (mem_read) begin
                nrd++;
                check("rd_addr", mem_addr, {a[63:3], 3'b000});
            end
            if (mem_write) begin
                nwr++;
                check("wr_addr", mem_addr, {a[63:3], 3'b000});
                check("wr_data", mem_wdata, exp_word);
            end
        end while (!resp_valid && lat < 10);
        check("latency", 64'(lat), 64'(exp_lat));
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", 64'(resp_err), 64'(mis));
        check("n_read", 64'(nrd), 64'(!mis && (!w || sz != 2'd3)));
        check("n_write", 64'(nwr), 64'(!mis && w));
        if (!mis && w) ref_mem[idx] = exp_word;

        // Backpressure with a hazardous request pending that must not be taken.
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
            req_addr = 64'(($urandom % 32) * 8); req_wdata = {$urandom, $urandom};
            @(negedge clk_in);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_rdata", resp_rdata, exp_rd);
            check("bp_err", 64'(resp_err), 64'(mis));
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_no_traffic", {62'd0, mem_read, mem_write}, 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk_in);
        resp_ready = 1'b0;
        check("released", {62'd0, resp_valid, req_ready}, 64'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fmem[i]    = {$urandom, $urandom};
            ref_mem[i] = fmem[i];
        end
        fmem[8]    = 64'h8877665544332211;
        ref_mem[8] = 64'h8877665544332211;

        repeat (2) @(negedge clk_in);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        @(negedge clk_in);

        do_req(1'b0, 2'd0, 1'b0, 64'h47, 64'd0, 0, 1'b1, 64'hFFFFFFFFFFFFFF88);
        do_req(1'b0, 2'd0, 1'b1, 64'h47, 64'd0, 0, 1'b1, 64'h0000000000000088);
        do_req(1'b0, 2'd2, 1'b0, 64'h44, 64'd0, 0, 1'b1, 64'hFFFFFFFF88776655);
        do_req(1'b1, 2'd1, 1'b0, 64'h42, 64'hBEEF, 0, 1'b1, 64'h88776655BEEF2211);
        do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 0, 1'b1, 64'h88776655BEEF2211);
        do_req(1'b1, 2'd3, 1'b0, 64'h48, 64'h0123456789ABCDEF, 0, 1'b1,
               64'h0123456789ABCDEF);
        do_req(1'b0, 2'd2, 1'b0, 64'h46, 64'd0, 0, 1'b0, 64'd0);
        do_req(1'b1, 2'd1, 1'b0, 64'h43, 64'h1234, 0, 1'b0, 64'd0);
        do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 3, 1'b0, 64'd0);

        // Reset asserted while a byte store sits in its write cycle.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'h51; req_wdata = 64'hA5;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0;
        check("rst_seq_rd", 64'(mem_read), 64'd1);
        @(negedge clk_in);
        check("rst_seq_wr", 64'(mem_write), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_seq_wr_gated", 64'(mem_write), 64'd0);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check("rst_seq_ready", 64'(req_ready), 64'd1);
        check("rst_seq_valid", 64'(resp_valid), 64'd0);
        check("rst_seq_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check("rst_seq_addr", mem_addr, 64'd0);
        check("rst_seq_wdata", mem_wdata, 64'd0);
        check("rst_seq_mem", fmem[10], ref_mem[10]);
        @(negedge clk_in);

        for (int t = 0; t < 200; t++) begin
            do_req(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                   64'($urandom_range(0, 255)), {$urandom, $urandom},
                   ($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : 0, 1'b0, 64'd0);
        end

        @(negedge clk_in);
        for (int i = 0; i < 32; i++) check("final_mem", fmem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
